// File: rtl/video2ram_capture.sv
// Writes the configured capture window of a pixel-qualified video stream into a line-buffer RAM
// and raises a sticky start trigger for readout. Define CAPTURE_TESTPATTERN_EN to write a coordinate pattern.
module video2ram_capture #(
   parameter int ADDR_WIDTH    = 14,
   parameter int DATA_WIDTH    = 24,
   parameter int TRIGGER_LINES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_hsync,
   input  logic                  in_vsync,
   input  logic [11:0]           h_start,
   input  logic [11:0]           h_end,
   input  logic [11:0]           v_start,
   input  logic [11:0]           v_end,
   input  logic [ADDR_WIDTH-1:0] line_length,
   input  logic [ADDR_WIDTH-1:0] ram_numwords,
   output logic [ADDR_WIDTH-1:0] wraddr,
   output logic [DATA_WIDTH-1:0] wrdata,
   output logic                  wren,
   output logic                  starttrigger,
   output logic                  field,
   output logic                  is_interlaced
);

   typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_CAPTURE} state_t;

   localparam int TW = (TRIGGER_LINES < 2) ? 1 : $clog2(TRIGGER_LINES + 1);

   state_t                state;
   logic                  hs_prev, vs_prev;
   logic [11:0]           x_cnt, y_cnt, vs_pos;
   logic [ADDR_WIDTH-1:0] addr_y;
   logic                  cap_seen, frame_active;
   logic                  s1_we, s1_last_cnt;
   logic [ADDR_WIDTH-1:0] s1_addr;
   logic [DATA_WIDTH-1:0] s1_data;
   logic                  wr_cnt;
   logic [TW-1:0]         trig_cnt;

   function automatic logic [11:0] sat_inc(input logic [11:0] v);
      return (v == 12'hFFF) ? v : v + 12'd1;
   endfunction

   logic                  hs_fall, vs_fall, win_ok;
   logic [11:0]           pix_x, pix_y;
   state_t                st_a, st_b;
   logic                  enter_cap, line_inc;
   logic [ADDR_WIDTH-1:0] addr_sum, addr_y_nxt, pix_addr;
   logic                  pix_we, pix_last, frame_active_nxt;
   logic [DATA_WIDTH-1:0] pix_data;

   // Per-pixel view: coordinates and state this pixel belongs to, after any sync edge it carries.
   always_comb begin
      hs_fall  = in_valid & hs_prev & ~in_hsync;
      vs_fall  = in_valid & vs_prev & ~in_vsync;
      win_ok   = (v_end > v_start);
      pix_x    = hs_fall ? 12'd0 : x_cnt;
      pix_y    = vs_fall ? 12'd0 : (hs_fall ? sat_inc(y_cnt) : y_cnt);
      st_a     = vs_fall ? ST_SYNC : state;
      st_b     = st_a;
      if (st_a == ST_SYNC && pix_y == v_start && win_ok)
         st_b = ST_CAPTURE;
      else if (st_a == ST_CAPTURE && pix_y == v_end)
         st_b = ST_SYNC;
      enter_cap = in_valid && (st_a == ST_SYNC) && (st_b == ST_CAPTURE);
      line_inc  = hs_fall && !vs_fall && (st_a == ST_CAPTURE) && (st_b == ST_CAPTURE);
      addr_sum  = addr_y + line_length;
      addr_y_nxt = addr_y;
      if (vs_fall)
         addr_y_nxt = '0;
      else if (line_inc)
         addr_y_nxt = (addr_sum > ram_numwords - line_length) ? '0 : addr_sum;
      pix_we   = in_valid && (st_b == ST_CAPTURE) && (pix_x >= h_start) && (pix_x < h_end);
      pix_addr = addr_y_nxt + ADDR_WIDTH'(pix_x - h_start);
      pix_last = (pix_x == h_end - 12'd1);
      frame_active_nxt = frame_active;
      if (enter_cap && !cap_seen)
         frame_active_nxt = 1'b1;
      else if (vs_fall)
         frame_active_nxt = 1'b0;
`ifdef CAPTURE_TESTPATTERN_EN
      pix_data = DATA_WIDTH'({pix_x[7:0], pix_y[7:0], pix_x[7:0] ^ pix_y[7:0]});
`else
      pix_data = in_data;
`endif
   end

   // Front end: sync tracking, counters, FSM and field detection advance only on qualified pixels.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         hs_prev       <= 1'b0;
         vs_prev       <= 1'b0;
         x_cnt         <= '0;
         y_cnt         <= '0;
         addr_y        <= '0;
         vs_pos        <= '0;
         field         <= 1'b0;
         is_interlaced <= 1'b0;
         cap_seen      <= 1'b0;
         frame_active  <= 1'b0;
      end else if (in_valid) begin
         hs_prev      <= in_hsync;
         vs_prev      <= in_vsync;
         x_cnt        <= sat_inc(pix_x);
         y_cnt        <= pix_y;
         state        <= st_b;
         addr_y       <= addr_y_nxt;
         frame_active <= frame_active_nxt;
         if (enter_cap)
            cap_seen <= 1'b1;
         if (vs_fall) begin
            vs_pos        <= pix_x;
            is_interlaced <= (pix_x != vs_pos);
            field         <= (pix_x != vs_pos) ? ~field : 1'b0;
         end
      end
   end

   // Two-stage write pipeline; the trigger counts completed line writes of the first captured frame.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_we        <= 1'b0;
         s1_last_cnt  <= 1'b0;
         s1_addr      <= '0;
         s1_data      <= '0;
         wren         <= 1'b0;
         wraddr       <= '0;
         wrdata       <= '0;
         wr_cnt       <= 1'b0;
         trig_cnt     <= '0;
         starttrigger <= 1'b0;
      end else begin
         s1_we       <= pix_we;
         s1_last_cnt <= pix_we && pix_last && frame_active_nxt;
         if (pix_we) begin
            s1_addr <= pix_addr;
            s1_data <= pix_data;
         end
         wren   <= s1_we;
         wr_cnt <= s1_last_cnt;
         if (s1_we) begin
            wraddr <= s1_addr;
            wrdata <= s1_data;
         end
         if (wr_cnt && !starttrigger) begin
            if (trig_cnt == TW'(TRIGGER_LINES - 1))
               starttrigger <= 1'b1;
            else
               trig_cnt <= trig_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_video2ram_capture.sv
// Scoreboard bench for video2ram_capture: directed frames, expected writes queued at issue time
// and checked by an independent write monitor.
module tb_video2ram_capture;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [23:0] in_data = '0;
   logic        in_hsync = 1'b1;
   logic        in_vsync = 1'b1;
   logic [11:0] h0 = 12'd4, h1 = 12'd14, v0 = 12'd3, v1 = 12'd9;
   logic [13:0] ll = 14'd10, nw = 14'd16384 - 14'd1;
   logic [13:0] wraddr;
   logic [23:0] wrdata;
   logic        wren, starttrigger, field, is_interlaced;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   logic [37:0] exp_q[$];
   int          exp_cyc_q[$];

   logic [13:0] trig_addr = 14'd19;
   bit          addr_seen = 0, trig_seen = 0;
   int          addr_cyc = -10, rise_cyc = 0;

   video2ram_capture dut (
      .clock(clk), .reset(rst), .in_valid(in_valid), .in_data(in_data),
      .in_hsync(in_hsync), .in_vsync(in_vsync),
      .h_start(h0), .h_end(h1), .v_start(v0), .v_end(v1),
      .line_length(ll), .ram_numwords(nw),
      .wraddr(wraddr), .wrdata(wrdata), .wren(wren),
      .starttrigger(starttrigger), .field(field), .is_interlaced(is_interlaced)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Write monitor: every wren pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (!rst && wren) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: addr %0h data %0h, none expected", wraddr, wrdata);
         end else begin
            logic [37:0] e;
            int ec;
            e  = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            chk("wr_addr", 64'(wraddr), 64'(e[37:24]));
            chk("wr_data", 64'(wrdata), 64'(e[23:0]));
            chk("wr_cycle", 64'(cyc), 64'(ec));
         end
         if (wraddr == trig_addr && !addr_seen) begin
            addr_seen = 1;
            addr_cyc  = cyc;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && starttrigger && !trig_seen) begin
         trig_seen = 1;
         rise_cyc  = cyc;
      end
   end

   function automatic logic [23:0] src_data(int f, int x, int y);
      return {4'(f), 10'(y), 10'(x)};
   endfunction

   function automatic logic [23:0] exp_data(int f, int x, int y);
`ifdef CAPTURE_TESTPATTERN_EN
      logic [7:0] xb, yb;
      xb = 8'(x);
      yb = 8'(y);
      return {xb, yb, xb ^ yb};
`else
      return src_data(f, x, y);
`endif
   endfunction

   // Line base address with the buffer wrap rule.
   function automatic int base_of(int r);
      int b = 0;
      for (int i = 0; i < r; i++) begin
         b = b + int'(ll);
         if (b > int'(nw) - int'(ll)) b = 0;
      end
      return b;
   endfunction

   task automatic pix(input logic hs, input logic vs, input logic [23:0] d,
                      input bit expw, input logic [13:0] ea, input logic [23:0] ed);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_hsync = hs;
      in_vsync = vs;
      in_data  = d;
      if (expw) begin
         exp_q.push_back({ea, ed});
         exp_cyc_q.push_back(cyc + 2);
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic preamble();
      for (int i = 0; i < 4; i++) pix(1'b1, 1'b1, 24'd0, 0, '0, '0);
   endtask

   task automatic reset_mid();
      int rcyc;
      @(posedge clk); #3;
      rst = 1'b1;
      in_valid = 1'b0;
      rcyc = cyc;
      while (exp_cyc_q.size() > 0 && exp_cyc_q[$] >= rcyc) begin
         void'(exp_q.pop_back());
         void'(exp_cyc_q.pop_back());
      end
      @(negedge clk);
      chk("rst_mid_wren", 64'(wren), 64'd0);
      chk("rst_mid_wraddr", 64'(wraddr), 64'd0);
      chk("rst_mid_trigger", 64'(starttrigger), 64'd0);
      chk("rst_mid_field", 64'(field), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // One frame: hsync low for pixels 0-1 of each line, vsync falls at (line 0, vs_x) for one line.
   task automatic send_frame(input int ppl, input int nl, input int vs_x, input bit with_vs,
                             input bit gap, input int f, input bit cap,
                             input int ab_line, input int ab_x);
      for (int y = 0; y < nl; y++) begin
         for (int x = 0; x < ppl; x++) begin
            logic hs, vs;
            bit   w;
            if (y == ab_line && x == ab_x) begin
               reset_mid();
               return;
            end
            hs = !(x < 2);
            vs = !(with_vs && ((y == 0 && x >= vs_x) || (y == 1 && x < vs_x)));
            w  = cap && y >= int'(v0) && y < int'(v1) && x >= int'(h0) && x < int'(h1);
            pix(hs, vs, src_data(f, x, y), w,
                14'(base_of(y - int'(v0)) + x - int'(h0)), exp_data(f, x, y));
            if (gap) idle();
         end
      end
      idle();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_wren", 64'(wren), 64'd0);
      chk("rst_wraddr", 64'(wraddr), 64'd0);
      chk("rst_wrdata", 64'(wrdata), 64'd0);
      chk("rst_trigger", 64'(starttrigger), 64'd0);
      chk("rst_field", 64'(field), 64'd0);
      chk("rst_interlaced", 64'(is_interlaced), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      nw = 14'd16383;

      // Small progressive frames, second one with in_valid toggling.
      preamble();
      send_frame(20, 12, 0, 1, 0, 1, 1, -1, -1);
      send_frame(20, 12, 0, 1, 1, 2, 1, -1, -1);
      send_frame(20, 12, 0, 1, 0, 3, 1, -1, -1);
      repeat (4) idle();
      chk("a_addr19_seen", 64'(addr_seen), 64'd1);
      chk("a_trig_rise", 64'(rise_cyc), 64'(addr_cyc + 1));
      chk("a_trig_held", 64'(starttrigger), 64'd1);
      chk("a_interlaced", 64'(is_interlaced), 64'd0);
      chk("a_field", 64'(field), 64'd0);

      // Misconfigured window, alternating vsync position.
      h0 = 12'd14; h1 = 12'd4;
      send_frame(20, 12, 8, 1, 0, 4, 0, -1, -1);
      chk("il1_interlaced", 64'(is_interlaced), 64'd1);
      chk("il1_field", 64'(field), 64'd1);
      send_frame(20, 12, 0, 1, 0, 5, 0, -1, -1);
      chk("il2_interlaced", 64'(is_interlaced), 64'd1);
      chk("il2_field", 64'(field), 64'd0);
      send_frame(20, 12, 8, 1, 0, 6, 0, -1, -1);
      chk("il3_interlaced", 64'(is_interlaced), 64'd1);
      chk("il3_field", 64'(field), 64'd1);
      send_frame(20, 12, 8, 1, 0, 7, 0, -1, -1);
      chk("il4_interlaced", 64'(is_interlaced), 64'd0);
      chk("il4_field", 64'(field), 64'd0);
      chk("il_trig_held", 64'(starttrigger), 64'd1);

      // Reset in the middle of a captured line, then lines without vsync must not write.
      h0 = 12'd4; h1 = 12'd14;
      send_frame(20, 12, 0, 1, 0, 8, 1, 5, 9);
      send_frame(20, 3, 0, 0, 0, 9, 0, -1, -1);
      repeat (4) idle();

      // Full-width capture exercising the buffer wrap and the trigger at the end of line 1.
      trig_seen = 0; addr_seen = 0; addr_cyc = -10; rise_cyc = 0;
      trig_addr = 14'd1279;
      h0 = 12'd10; h1 = 12'd650; v0 = 12'd2; v1 = 12'd29; ll = 14'd640;
      send_frame(660, 31, 0, 1, 0, 10, 1, -1, -1);
      repeat (4) idle();
      chk("b_addr1279_seen", 64'(addr_seen), 64'd1);
      chk("b_trig_rise", 64'(rise_cyc), 64'(addr_cyc + 1));
      send_frame(20, 1, 0, 1, 0, 11, 1, -1, -1);
      repeat (4) idle();
      chk("b_trig_held", 64'(starttrigger), 64'd1);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
